// File: rtl/lane_player_controller.sv
// Player lane controller for the lane-based shooter.
// Turns debounced left/right key levels into a lane index and pixel
// coordinates. Key presses are latched between frame ticks, an optional
// hold-to-repeat moves the player while a key stays down, and pressing
// both keys locks movement until both are released.
//
// state  | meaning
// IDLE   | no key held; apply a latched request on the next tick
// HOLD_L | left key held after a move; counts ticks for auto-repeat
// HOLD_R | right key held after a move; counts ticks for auto-repeat
// LOCK   | both keys involved; no moves until both keys are low
module lane_player_controller #(
    parameter int NUM_LANES    = 4,
    parameter int LANE_W       = 2,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int X_BASE       = 14,
    parameter int X_PITCH      = 40,
    parameter int Y_POS        = 99,
    parameter int WRAP         = 0,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 8,
    parameter int CNT_W        = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              repeat_en,
    output logic [LANE_W-1:0] lane,
    output logic [X_W-1:0]    x_current,
    output logic [Y_W-1:0]    y_current,
    output logic              moved,
    output logic              blocked,
    output logic              at_left,
    output logic              at_right
);

    typedef enum logic [1:0] {IDLE, HOLD_L, HOLD_R, LOCK} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_LEFT, REQ_RIGHT} req_t;

    localparam logic [LANE_W-1:0] LAST     = LANE_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0]  DELAY_TC = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0]  RATE_TC  = CNT_W'(REPEAT_RATE);
    localparam logic [X_W-1:0]    BASE_C   = X_W'(X_BASE);
    localparam logic [X_W-1:0]    PITCH_C  = X_W'(X_PITCH);

    state_t            state;
    req_t              req;
    logic [CNT_W-1:0]  hold_cnt;
    logic              first_done;
    logic              left_q;
    logic              right_q;

    logic              rise_l;
    logic              rise_r;
    logic              lock_rise;
    logic              held;
    logic              other;
    logic [CNT_W-1:0]  cnt_inc;
    logic              rep_hit;
    logic              apply;
    logic              dir_left;
    logic              at_edge;
    logic [LANE_W-1:0] next_lane;
    logic              next_moved;
    logic              next_blocked;

    assign rise_l    = key_left & ~left_q;
    assign rise_r    = key_right & ~right_q;
    assign lock_rise = (rise_l & key_right) | (rise_r & key_left);
    assign held      = (state == HOLD_L) ? key_left : key_right;
    assign other     = (state == HOLD_L) ? key_right : key_left;
    assign cnt_inc   = hold_cnt + 1'b1;
    // first repeat waits the long delay, later repeats use the rate
    assign rep_hit   = tick & repeat_en & (cnt_inc == (first_done ? RATE_TC : DELAY_TC));

    assign y_current = Y_W'(Y_POS);
    assign at_left   = (lane == '0);
    assign at_right  = (lane == LAST);

    // decide whether this cycle applies a move and in which direction
    always_comb begin
        apply    = 1'b0;
        dir_left = 1'b0;
        case (state)
            IDLE: begin
                if (!lock_rise && tick && req != REQ_NONE) begin
                    apply    = 1'b1;
                    dir_left = (req == REQ_LEFT);
                end
            end
            HOLD_L: begin
                if (held && !other && rep_hit) begin
                    apply    = 1'b1;
                    dir_left = 1'b1;
                end
            end
            HOLD_R: begin
                if (held && !other && rep_hit) begin
                    apply = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // resolve a move against the edge lanes (wrap or block)
    always_comb begin
        at_edge      = dir_left ? (lane == '0) : (lane == LAST);
        next_lane    = lane;
        next_moved   = 1'b0;
        next_blocked = 1'b0;
        if (apply) begin
            if (!at_edge) begin
                next_lane  = dir_left ? (lane - 1'b1) : (lane + 1'b1);
                next_moved = 1'b1;
            end else if (WRAP != 0) begin
                next_lane  = dir_left ? LAST : '0;
                next_moved = 1'b1;
            end else begin
                next_blocked = 1'b1;
            end
        end
    end

    // state machine, request latch and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            req        <= REQ_NONE;
            hold_cnt   <= '0;
            first_done <= 1'b0;
            left_q     <= 1'b1;   // a key held through reset needs a release first
            right_q    <= 1'b1;
            lane       <= '0;
            x_current  <= BASE_C;
            moved      <= 1'b0;
            blocked    <= 1'b0;
        end else begin
            left_q    <= key_left;
            right_q   <= key_right;
            lane      <= next_lane;
            x_current <= BASE_C + X_W'(next_lane) * PITCH_C;
            moved     <= next_moved;
            blocked   <= next_blocked;

            // a fresh press always wins over clearing the consumed request
            if (state == LOCK || lock_rise)
                req <= REQ_NONE;
            else if (rise_l)
                req <= REQ_LEFT;
            else if (rise_r)
                req <= REQ_RIGHT;
            else if (state == IDLE && apply)
                req <= REQ_NONE;

            case (state)
                IDLE: begin
                    if (lock_rise) begin
                        state <= LOCK;
                    end else if (apply) begin
                        state      <= dir_left ? HOLD_L : HOLD_R;
                        hold_cnt   <= '0;
                        first_done <= 1'b0;
                    end
                end
                HOLD_L, HOLD_R: begin
                    if (!held) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (other) begin
                        state    <= LOCK;
                        hold_cnt <= '0;
                    end else if (!repeat_en) begin
                        hold_cnt <= '0;
                    end else if (tick) begin
                        if (rep_hit) begin
                            hold_cnt   <= '0;
                            first_done <= 1'b1;
                        end else begin
                            hold_cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    if (!key_left && !key_right)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_player_controller.sv
// Bench for lane_player_controller: two instances (no wrap / wrap) share
// the same stimulus and are compared every cycle against a behavioural
// model, plus directed scenario checks with fixed expected values.
module tb_lane_player_controller;

    localparam int N     = 4;
    localparam int XB    = 14;
    localparam int XP    = 40;
    localparam int DELAY = 30;
    localparam int RATE  = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic tick = 1'b0;
    logic key_left = 1'b0;
    logic key_right = 1'b0;
    logic repeat_en = 1'b0;

    logic [1:0] lane_o [2];
    logic [7:0] x_o [2];
    logic [6:0] y_o [2];
    logic       moved_o [2];
    logic       blocked_o [2];
    logic       at_left_o [2];
    logic       at_right_o [2];

    int tests = 0;
    int fails = 0;

    // model state: mode 0 idle, 1 holding, 2 locked; directions -1/+1
    int m_lane [2];
    int m_mode [2];
    int m_dir [2];
    int m_pend [2];
    int m_cnt [2];
    int m_first [2];
    bit m_moved [2];
    bit m_blocked [2];
    bit m_prev_l = 1'b1;
    bit m_prev_r = 1'b1;
    int n_ev [2];

    always #5 clk = ~clk;

    lane_player_controller #(.WRAP(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .tick(tick), .key_left(key_left),
        .key_right(key_right), .repeat_en(repeat_en), .lane(lane_o[0]),
        .x_current(x_o[0]), .y_current(y_o[0]), .moved(moved_o[0]),
        .blocked(blocked_o[0]), .at_left(at_left_o[0]), .at_right(at_right_o[0])
    );

    lane_player_controller #(.WRAP(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .tick(tick), .key_left(key_left),
        .key_right(key_right), .repeat_en(repeat_en), .lane(lane_o[1]),
        .x_current(x_o[1]), .y_current(y_o[1]), .moved(moved_o[1]),
        .blocked(blocked_o[1]), .at_left(at_left_o[1]), .at_right(at_right_o[1])
    );

    task automatic model_step(input bit rn, input bit t, input bit kl, input bit kr, input bit re);
        bit rl;
        bit rr;
        bit lockr;
        rl    = kl && !m_prev_l;
        rr    = kr && !m_prev_r;
        lockr = (rl && kr) || (rr && kl);
        for (int i = 0; i < 2; i++) begin
            int go;
            int old_mode;
            m_moved[i]   = 1'b0;
            m_blocked[i] = 1'b0;
            if (!rn) begin
                m_lane[i] = 0; m_mode[i] = 0; m_pend[i] = 0; m_cnt[i] = 0; m_first[i] = 0;
                continue;
            end
            go = 0;
            old_mode = m_mode[i];
            if (old_mode == 0) begin
                if (lockr) m_mode[i] = 2;
                else if (t && m_pend[i] != 0) begin
                    go = m_pend[i]; m_dir[i] = go; m_mode[i] = 1; m_cnt[i] = 0; m_first[i] = 0;
                end
            end else if (old_mode == 1) begin
                if (!(m_dir[i] < 0 ? kl : kr)) m_mode[i] = 0;
                else if (m_dir[i] < 0 ? kr : kl) m_mode[i] = 2;
                else if (!re) m_cnt[i] = 0;
                else if (t) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == (m_first[i] != 0 ? RATE : DELAY)) begin
                        go = m_dir[i]; m_cnt[i] = 0; m_first[i] = 1;
                    end
                end
            end else if (!kl && !kr) begin
                m_mode[i] = 0;
            end
            if (old_mode == 2 || lockr) m_pend[i] = 0;
            else if (rl) m_pend[i] = -1;
            else if (rr) m_pend[i] = 1;
            else if (go != 0 && old_mode == 0) m_pend[i] = 0;
            if (go != 0) begin
                int tgt;
                tgt = m_lane[i] + go;
                if (tgt >= 0 && tgt < N) begin
                    m_lane[i] = tgt; m_moved[i] = 1'b1;
                end else if (i == 1) begin
                    m_lane[i] = (tgt + N) % N; m_moved[i] = 1'b1;
                end else begin
                    m_blocked[i] = 1'b1;
                end
            end
        end
        m_prev_l = rn ? kl : 1'b1;
        m_prev_r = rn ? kr : 1'b1;
    endtask

    // one clock: drive at negedge, step model at posedge, compare just after
    task automatic cyc(input bit rn, input bit t, input bit kl, input bit kr, input bit re);
        @(negedge clk);
        resetn = rn; tick = t; key_left = kl; key_right = kr; repeat_en = re;
        @(posedge clk);
        model_step(rn, t, kl, kr, re);
        #1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (lane_o[i] !== 2'(m_lane[i]) || x_o[i] !== 8'(XB + XP * m_lane[i]) ||
                y_o[i] !== 7'd99 || moved_o[i] !== m_moved[i] || blocked_o[i] !== m_blocked[i] ||
                at_left_o[i] !== (m_lane[i] == 0) || at_right_o[i] !== (m_lane[i] == N - 1) ||
                (moved_o[i] === 1'b1 && blocked_o[i] === 1'b1)) begin
                fails++;
                $display("FAIL model dut%0d t=%0t: got lane=%0d x=%0d y=%0d mv=%b bl=%b al=%b ar=%b, want lane=%0d x=%0d mv=%b bl=%b",
                         i, $time, lane_o[i], x_o[i], y_o[i], moved_o[i], blocked_o[i],
                         at_left_o[i], at_right_o[i], m_lane[i], 8'(XB + XP * m_lane[i]),
                         m_moved[i], m_blocked[i]);
            end
            if (moved_o[i] === 1'b1 || blocked_o[i] === 1'b1) n_ev[i]++;
        end
    endtask

    task automatic reset_dut();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        tests++;
        if (lane_o[0] !== 2'd0 || x_o[0] !== 8'd14 || moved_o[0] !== 1'b0 ||
            blocked_o[0] !== 1'b0 || at_left_o[0] !== 1'b1 || at_right_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset: got lane=%0d x=%0d mv=%b bl=%b al=%b ar=%b, want 0 14 0 0 1 0",
                     lane_o[0], x_o[0], moved_o[0], blocked_o[0], at_left_o[0], at_right_o[0]);
        end
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic test_single_move();
        reset_dut();
        repeat (3) cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        tests++;
        if (lane_o[0] !== 2'd1 || x_o[0] !== 8'd54 || moved_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_move: got lane=%0d x=%0d mv=%b, want 1 54 1", lane_o[0], x_o[0], moved_o[0]);
        end
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        tests++;
        if (lane_o[0] !== 2'd1 || moved_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL second_tick: got lane=%0d mv=%b, want 1 0", lane_o[0], moved_o[0]);
        end
    endtask

    task automatic test_auto_repeat();
        int ev_ticks [$];
        int want [4] = '{1, 31, 39, 47};
        reset_dut();
        cyc(1, 0, 0, 1, 1);
        for (int tk = 1; tk <= 50; tk++) begin
            cyc(1, 1, 0, 1, 1);
            if (moved_o[0] === 1'b1 || blocked_o[0] === 1'b1) ev_ticks.push_back(tk);
            repeat (3) cyc(1, 0, 0, 1, 1);
        end
        tests++;
        if (ev_ticks.size() != 4) begin
            fails++;
            $display("FAIL repeat_count: got %0d events, want 4", ev_ticks.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (ev_ticks[k] != want[k]) begin
                    fails++;
                    $display("FAIL repeat_tick%0d: got tick %0d, want %0d", k, ev_ticks[k], want[k]);
                end
            end
        end
        tests++;
        if (lane_o[0] !== 2'd3 || lane_o[1] !== 2'd0) begin
            fails++;
            $display("FAIL repeat_lanes: got %0d/%0d, want 3/0", lane_o[0], lane_o[1]);
        end
        n_ev[0] = 0;
        n_ev[1] = 0;
        cyc(1, 0, 0, 0, 1);
        repeat (40) begin
            cyc(1, 1, 0, 0, 1);
            cyc(1, 0, 0, 0, 1);
        end
        tests++;
        if (n_ev[0] != 0 || n_ev[1] != 0) begin
            fails++;
            $display("FAIL after_release: got %0d/%0d events, want 0/0", n_ev[0], n_ev[1]);
        end
    endtask

    task automatic test_lock();
        reset_dut();
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        n_ev[0] = 0;
        n_ev[1] = 0;
        cyc(1, 0, 1, 1, 1);
        repeat (5) begin
            cyc(1, 1, 1, 1, 1);
            cyc(1, 0, 1, 1, 1);
        end
        tests++;
        if (lane_o[0] !== 2'd1 || lane_o[1] !== 2'd1 || n_ev[0] != 0 || n_ev[1] != 0) begin
            fails++;
            $display("FAIL lock_hold: got lanes %0d/%0d events %0d/%0d, want 1/1 0/0",
                     lane_o[0], lane_o[1], n_ev[0], n_ev[1]);
        end
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        tests++;
        if (lane_o[0] !== 2'd0 || lane_o[1] !== 2'd0 || moved_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL lock_release: got lanes %0d/%0d mv=%b, want 0/0 1", lane_o[0], lane_o[1], moved_o[0]);
        end
    endtask

    task automatic test_reset_hold_and_edge();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        n_ev[0] = 0;
        n_ev[1] = 0;
        cyc(1, 0, 1, 0, 0);
        repeat (3) begin
            cyc(1, 1, 1, 0, 0);
            cyc(1, 0, 1, 0, 0);
        end
        tests++;
        if (n_ev[0] != 0 || n_ev[1] != 0 || lane_o[0] !== 2'd0) begin
            fails++;
            $display("FAIL held_through_reset: got events %0d/%0d lane=%0d, want 0/0 0", n_ev[0], n_ev[1], lane_o[0]);
        end
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        tests++;
        if (lane_o[0] !== 2'd0 || blocked_o[0] !== 1'b1 || moved_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL left_edge_block: got lane=%0d bl=%b mv=%b, want 0 1 0", lane_o[0], blocked_o[0], moved_o[0]);
        end
        tests++;
        if (lane_o[1] !== 2'd3 || x_o[1] !== 8'd134 || moved_o[1] !== 1'b1 || blocked_o[1] !== 1'b0) begin
            fails++;
            $display("FAIL left_edge_wrap: got lane=%0d x=%0d mv=%b bl=%b, want 3 134 1 0",
                     lane_o[1], x_o[1], moved_o[1], blocked_o[1]);
        end
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic test_tick_coincident();
        reset_dut();
        cyc(1, 1, 0, 1, 0);
        tests++;
        if (lane_o[0] !== 2'd0 || moved_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL coincident_first: got lane=%0d mv=%b, want 0 0", lane_o[0], moved_o[0]);
        end
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        tests++;
        if (lane_o[0] !== 2'd1 || moved_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL coincident_next: got lane=%0d mv=%b, want 1 1", lane_o[0], moved_o[0]);
        end
    endtask

    task automatic test_random();
        bit kl = 1'b0;
        bit kr = 1'b0;
        bit re = 1'b1;
        reset_dut();
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(59) == 0) kl = !kl;
            if ($urandom_range(59) == 0) kr = !kr;
            if ($urandom_range(299) == 0) re = !re;
            cyc(($urandom_range(799) != 0), ($urandom_range(2) == 0), kl, kr, re);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_lane[i] = 0; m_mode[i] = 0; m_dir[i] = 1; m_pend[i] = 0;
            m_cnt[i] = 0; m_first[i] = 0; m_moved[i] = 1'b0; m_blocked[i] = 1'b0; n_ev[i] = 0;
        end
        test_reset();
        test_single_move();
        test_auto_repeat();
        test_lock();
        test_reset_hold_and_edge();
        test_tick_coincident();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
